// File: rtl/mapped_spi_flash_burst.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mapped_spi_flash_burst: memory-mapped SPI NOR word reader, fast read     |
// | with divided SCK and sequential-burst chip-select hold.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mapped_spi_flash_burst #(
   parameter int         ADDR_W         = 20,
   parameter logic [7:0] READ_CMD       = 8'h0B,
   parameter int         DUMMY_CYCLES   = 8,
   parameter int         CLK_DIV        = 1,
   parameter int         HOLD_CYCLES    = 16,
   parameter int         CS_HIGH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              rstrb,
   input  logic [ADDR_W-1:0] word_address,
   output logic [31:0]       rdata,
   output logic              rvalid,
   output logic              rbusy,
   output logic              spi_clk,
   output logic              spi_cs_n,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CMD   = 3'd1,
      S_ADDR  = 3'd2,
      S_DUMMY = 3'd3,
      S_DATA  = 3'd4,
      S_DONE  = 3'd5,
      S_HOLD  = 3'd6,
      S_DESEL = 3'd7
   } state_t;

   localparam logic [15:0] c_div_max = 16'(CLK_DIV - 1);

   state_t      r_state;
   logic [15:0] r_div;
   logic [15:0] r_wait;
   logic [7:0]  r_bits;
   logic [31:0] r_tx;
   logic [31:0] r_rx;
   logic [31:0] r_rdata;
   logic [21:0] r_word;
   logic [21:0] r_next;
   logic        r_pend;
   logic        r_sck;
   logic        r_cs_n;
   logic        r_mosi;
   logic        r_rvalid;
   logic        r_rbusy;

   logic [21:0] w_req_word;
   logic [21:0] w_start_word;
   logic        w_sck_on;
   logic        w_tick;
   logic        w_rise;
   logic        w_fall;
   logic        w_hold_exp;
   logic        w_desel_exp;
   logic        w_desel_take;
   logic        w_start;

   always_comb begin
      w_req_word   = 22'(word_address);
      w_sck_on     = (r_state == S_CMD) || (r_state == S_ADDR) ||
                     (r_state == S_DUMMY) || (r_state == S_DATA);
      w_tick       = w_sck_on && (r_div == c_div_max);
      w_rise       = w_tick && !r_sck;
      w_fall       = w_tick && r_sck;
      w_hold_exp   = (int'(r_wait) + 1 >= HOLD_CYCLES);
      w_desel_exp  = (int'(r_wait) + 1 >= CS_HIGH_CYCLES);
      w_desel_take = (r_state == S_DESEL) && rstrb && !r_rbusy && !r_pend;
      // A request may arrive in the very cycle the deselect gap ends.
      w_start      = ((r_state == S_IDLE) && rstrb) ||
                     ((r_state == S_DESEL) && w_desel_exp && (r_pend || w_desel_take));
      w_start_word = ((r_state == S_DESEL) && !w_desel_take) ? r_word : w_req_word;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= S_IDLE;
         r_div    <= '0;
         r_wait   <= '0;
         r_bits   <= '0;
         r_tx     <= '0;
         r_rx     <= '0;
         r_rdata  <= '0;
         r_word   <= '0;
         r_next   <= '0;
         r_pend   <= 1'b0;
         r_sck    <= 1'b0;
         r_cs_n   <= 1'b1;
         r_mosi   <= 1'b0;
         r_rvalid <= 1'b0;
         r_rbusy  <= 1'b0;
      end else begin
         r_rvalid <= 1'b0;
         if (r_rvalid) r_rbusy <= 1'b0;
         if (w_sck_on) begin
            if (w_tick) begin
               r_div <= '0;
               r_sck <= ~r_sck;
            end else begin
               r_div <= r_div + 16'd1;
            end
         end
         if (w_rise && (r_state == S_DATA)) r_rx <= {r_rx[30:0], spi_miso};

         case (r_state)
            S_CMD, S_ADDR: begin
               if (w_fall) begin
                  r_tx   <= {r_tx[30:0], 1'b0};
                  r_mosi <= r_tx[30];
                  r_bits <= r_bits + 8'd1;
                  if ((r_state == S_CMD) && (r_bits == 8'd7)) begin
                     r_state <= S_ADDR;
                     r_bits  <= '0;
                  end else if ((r_state == S_ADDR) && (r_bits == 8'd23)) begin
                     r_state <= (DUMMY_CYCLES > 0) ? S_DUMMY : S_DATA;
                     r_bits  <= '0;
                     r_mosi  <= 1'b0;
                  end
               end
            end
            S_DUMMY: begin
               if (w_fall) begin
                  if (int'(r_bits) == DUMMY_CYCLES - 1) begin
                     r_state <= S_DATA;
                     r_bits  <= '0;
                  end else begin
                     r_bits <= r_bits + 8'd1;
                  end
               end
            end
            S_DATA: begin
               if (w_fall) begin
                  if (r_bits == 8'd31) r_state <= S_DONE;
                  else                 r_bits  <= r_bits + 8'd1;
               end
            end
            S_DONE: begin
               // First flash byte landed in the top of the shift register.
               r_rdata  <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
               r_rvalid <= 1'b1;
               r_next   <= r_word + 22'd1;
               r_wait   <= '0;
               r_state  <= S_HOLD;
            end
            S_HOLD: begin
               if (rstrb && !r_rbusy) begin
                  r_rbusy <= 1'b1;
                  r_word  <= w_req_word;
                  if (w_req_word == r_next) begin
                     r_state <= S_DATA;
                     r_bits  <= '0;
                     r_div   <= '0;
                     r_sck   <= 1'b0;
                  end else begin
                     r_pend  <= 1'b1;
                     r_cs_n  <= 1'b1;
                     r_wait  <= '0;
                     r_state <= S_DESEL;
                  end
               end else if (w_hold_exp) begin
                  r_cs_n  <= 1'b1;
                  r_wait  <= '0;
                  r_state <= S_DESEL;
               end else begin
                  r_wait <= r_wait + 16'd1;
               end
            end
            S_DESEL: begin
               if (w_desel_take) begin
                  r_word  <= w_req_word;
                  r_pend  <= 1'b1;
                  r_rbusy <= 1'b1;
               end
               if (w_desel_exp) begin
                  if (!(r_pend || w_desel_take)) r_state <= S_IDLE;
               end else begin
                  r_wait <= r_wait + 16'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_start) begin
            r_state <= S_CMD;
            r_cs_n  <= 1'b0;
            r_rbusy <= 1'b1;
            r_pend  <= 1'b0;
            r_word  <= w_start_word;
            r_tx    <= {READ_CMD, w_start_word, 2'b00};
            r_mosi  <= READ_CMD[7];
            r_bits  <= '0;
            r_div   <= '0;
            r_sck   <= 1'b0;
         end
      end
   end

   assign rdata    = r_rdata;
   assign rvalid   = r_rvalid;
   assign rbusy    = r_rbusy;
   assign spi_clk  = r_sck;
   assign spi_cs_n = r_cs_n;
   assign spi_mosi = r_mosi;

endmodule
`default_nettype wire

// File: doc/mapped_spi_flash_burst.md
Name: mapped_spi_flash_burst

Overview:
- Parametrised successor to the memory-mapped SPI flash word reader: the CPU strobes a word address and receives a 32-bit little-endian word from SPI NOR flash.
- Adds a configurable command byte and dummy cycles (fast read), an SCK divider in place of the gated system clock, and an rvalid handshake.
- Adds a sequential-burst hold mode: CS_N stays low after a word, so a read of the next word skips the command, address and dummy phases.
- Sits between the instruction/data bus and the board flash pins.

Parameters:
- ADDR_W, 20, word-address width; 1..22 (byte address = {word_address,2'b00} zero-extended to 24 bits).
- READ_CMD, 8'h0B, command byte sent MSB first.
- DUMMY_CYCLES, 8, SCK cycles between address and data; 0 allowed (use with READ_CMD 8'h03).
- CLK_DIV, 1, SCK half-period in clk cycles; >=1; SCK = clk/(2*CLK_DIV).
- HOLD_CYCLES, 16, clk cycles CS_N stays low waiting for a sequential read; 0 disables burst hold.
- CS_HIGH_CYCLES, 2, minimum clk cycles CS_N high between transactions; >=1.

Ports:
- clk  in  1  system clock, all logic on posedge.
- resetn  in  1  asynchronous active-low reset.
- rstrb  in  1  read request, one-cycle pulse.
- word_address  in  ADDR_W  word address, sampled when rstrb is accepted.
- rdata  out  32  read word, first flash byte in [7:0]; stable until the next rvalid.
- rvalid  out  1  one-cycle pulse when rdata is updated.
- rbusy  out  1  high while a request is in flight.
- spi_clk  out  1  SPI clock, mode 0, idles low.
- spi_cs_n  out  1  chip select, active low.
- spi_mosi  out  1  master out.
- spi_miso  in  1  master in.

Behaviour:
- Reset (async, on resetn low): state IDLE; spi_cs_n=1, spi_clk=0, spi_mosi=0, rvalid=0, rbusy=0, rdata=0, all counters 0. Reset mid-transaction aborts immediately with the same values; no rvalid is produced.
- All outputs are registered; spi_clk is never derived combinationally from clk.
- SCK: a divider toggles spi_clk every CLK_DIV clk cycles while in CMD/ADDR/DUMMY/DATA.
  - spi_mosi changes only on the falling edge (or on CS_N assertion, for the first bit).
  - spi_miso is sampled in the clk cycle that raises spi_clk.
- Acceptance: rstrb is accepted only when rbusy=0. rbusy rises the cycle after acceptance and falls in the same cycle rvalid pulses. rstrb while rbusy=1 is ignored, with no queueing.
- States:
  - IDLE: cs_n=1. rstrb -> CMD; load shift register {READ_CMD, byte address}; cs_n goes 0.
  - CMD: 8 SCK cycles -> ADDR.
  - ADDR: 24 SCK cycles, address MSB first -> DUMMY if DUMMY_CYCLES>0, else DATA. spi_mosi=0 during DUMMY.
  - DATA: 32 SCK cycles, shifting in MISO. On completion: rdata = byte-swizzled word (received byte0 -> [7:0], byte3 -> [31:24]); rvalid pulses; next_addr = addr+1 (24-bit wrap). Then HOLD if HOLD_CYCLES>0, else DESELECT.
  - HOLD: cs_n=0, spi_clk=0, counting HOLD_CYCLES.
    - rstrb with byte address == next_addr -> DATA directly (burst hit).
    - rstrb with any other address -> latch the address, DESELECT, then CMD (miss).
    - Counter expiry -> DESELECT, then IDLE.
    - rstrb in the expiry cycle is treated as taken in HOLD.
  - DESELECT: cs_n=1 for CS_HIGH_CYCLES, then CMD if a request is latched, else IDLE.
- Latency from rstrb (cycle 0) to rvalid:
  - Fresh read: 2*CLK_DIV*(32+DUMMY_CYCLES+32)+2 cycles.
  - Burst hit: 2*CLK_DIV*32+2.
  - Miss from HOLD: CS_HIGH_CYCLES + fresh latency.
- Address wrap: word address 0x3FFFFF + 1 -> 0x000000; a hit on that wrap is legal.

Test Plan:
- Reset, then rstrb with word_address=0x00010, defaults; flash model returns bytes 11,22,33,44 -> MOSI carries 0x0B,0x000040 and 8 dummy cycles; rvalid at cycle 146 with rdata=0x44332211; rbusy high cycles 1..146.
- Second rstrb at 0x00011 within 16 cycles of rvalid -> no command resent, cs_n never rises, rvalid after 66 cycles, next 4 bytes returned.
- rstrb at 0x00050 while in HOLD after reading 0x00011 -> cs_n high for exactly 2 cycles, full command with address 0x000140, rvalid after 148 cycles.
- READ_CMD=8'h03, DUMMY_CYCLES=0, CLK_DIV=2, HOLD_CYCLES=0 -> SCK period 4 clk, rvalid at cycle 258, cs_n rises 1 cycle after rvalid.
- resetn pulsed low mid-ADDR phase -> cs_n=1, spi_clk=0, rbusy=0 asynchronously, no rvalid; a subsequent rstrb completes normally.
- rstrb pulses during DATA phase -> ignored; exactly one rvalid, rdata from the original address.
